mac_udp_rx: RTL and testbench

//  Byte-wide Ethernet/IPv4/UDP frame receiver for the PHY RX side (GMII-style RX_DV/RX_Data).

---
 rtl/mac_udp_rx.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_mac_udp_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_udp_rx.sv
// -----------------------------------------------------------------------------
// mac_udp_rx
//   Byte-wide Ethernet/IPv4/UDP receiver on the PHY RX side (GMII-style
//   RX_DV/RX_Data). Strips preamble and SFD. Filters on destination MAC
//   (local or broadcast), ethertype, IP version/IHL, protocol, destination IP
//   and UDP destination port. Verifies the IP header checksum and the FCS.
//   Streams the UDP payload with SOF/EOF markers. The IP header is fixed at
//   20 bytes, with no options.
//
// Ports
//   clk            byte clock; all logic on the rising edge
//   RST            synchronous reset, active high
//   RX_DV, RX_Data receive data valid and byte from the PHY
//   Payload_*      payload byte stream: Valid/Data/SOF/EOF, one cycle after input
//   Payload_Len    UDP length - 8, published when the UDP header completes
//   Src_IP         source IP of the accepted frame
//   Src_Port       source UDP port of the accepted frame
//   Frame_Done     1-cycle pulse after a frame that reached PAYLOAD or PAD_FCS
//   Frame_Good     pulses together with Frame_Done: FCS good and no truncation
//   Drop_Cnt       saturating count of frames rejected before the payload
// -----------------------------------------------------------------------------
module mac_udp_rx #(
   parameter logic [47:0] LOCAL_MAC  = 48'h081F7102C777,
   parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
   parameter logic [15:0] LOCAL_PORT = 16'd6000
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        RX_DV,
   input  logic [7:0]  RX_Data,
   output logic        Payload_Valid,
   output logic [7:0]  Payload_Data,
   output logic        Payload_SOF,
   output logic        Payload_EOF,
   output logic [15:0] Payload_Len,
   output logic [31:0] Src_IP,
   output logic [15:0] Src_Port,
   output logic        Frame_Done,
   output logic        Frame_Good,
   output logic [15:0] Drop_Cnt
);

   typedef enum logic [3:0] {
      S_WAIT_IDLE, S_IDLE, S_PREAMBLE, S_DST_MAC, S_SRC_MAC, S_ETYPE,
      S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_PAD_FCS, S_DROP
   } state_t;

   // Register value left by a reflected CRC-32 that has absorbed its own FCS
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;               // byte index within the current header
   logic [7:0]  hi_q, hi_d;                 // previous byte = high half of 16-bit fields
   logic [15:0] csum_q, csum_d;             // running ones-complement IP header sum
   logic [31:0] crc_q, crc_d;
   logic        uc_q, uc_d, bc_q, bc_d;     // DA still matches unicast / broadcast
   logic [31:0] ip_hold_q, ip_hold_d;       // source IP, published only on acceptance
   logic [15:0] port_hold_q, port_hold_d;
   logic [15:0] len_q, len_d;               // UDP length field
   logic [15:0] rem_q, rem_d;               // payload bytes still expected
   logic        sof_pend_q, sof_pend_d;

   logic        pvalid_q, pvalid_d, psof_q, psof_d, peof_q, peof_d;
   logic [7:0]  pdata_q, pdata_d;
   logic [15:0] plen_q, plen_d, sport_q, sport_d, drop_q, drop_d;
   logic [31:0] sip_q, sip_d;
   logic        done_q, done_d, good_q, good_d;

   logic        drop_now, trunc;
   logic [15:0] word;
   logic [16:0] csum_sum;
   logic [15:0] csum_fold;
   logic [7:0]  mac_byte, ip_byte;

   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   assign word      = {hi_q, RX_Data};
   assign csum_sum  = {1'b0, csum_q} + {1'b0, word};
   // End-around carry; a second carry cannot occur because the sum is at most 0x1FFFE
   assign csum_fold = csum_sum[15:0] + {15'd0, csum_sum[16]};
   assign mac_byte  = 8'(LOCAL_MAC >> {(3'd5 - cnt_q[2:0]), 3'b000});
   assign ip_byte   = 8'(LOCAL_IP >> {(2'd3 - cnt_q[1:0]), 3'b000});

   always_comb begin
      // NOTE: every variable gets its hold or default value first, so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q + 5'd1;
      hi_d        = RX_DV ? RX_Data : hi_q;
      csum_d      = csum_q;
      uc_d        = uc_q;
      bc_d        = bc_q;
      ip_hold_d   = ip_hold_q;
      port_hold_d = port_hold_q;
      len_d       = len_q;
      rem_d       = rem_q;
      sof_pend_d  = sof_pend_q;
      pvalid_d    = 1'b0;
      pdata_d     = pdata_q;
      psof_d      = 1'b0;
      peof_d      = 1'b0;
      plen_d      = plen_q;
      sip_d       = sip_q;
      sport_d     = sport_q;
      done_d      = 1'b0;
      good_d      = 1'b0;
      drop_now    = 1'b0;
      trunc       = 1'b0;

      // The CRC covers DA through FCS; it stays preset until the SFD is seen
      case (state_q)
         S_DST_MAC, S_SRC_MAC, S_ETYPE, S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_PAD_FCS:
            crc_d = RX_DV ? crc_byte(crc_q, RX_Data) : '1;
         default: crc_d = '1;
      endcase

      if (!RX_DV) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         case (state_q)
            S_PREAMBLE, S_DST_MAC, S_SRC_MAC, S_ETYPE, S_IP_HDR, S_UDP_HDR: trunc = 1'b1;
            S_PAYLOAD: done_d = 1'b1;
            S_PAD_FCS: begin
               done_d = 1'b1;
               good_d = (crc_q == CRC_RESIDUE);
            end
            default: ;
         endcase
      end else begin
         case (state_q)
            S_IDLE, S_PREAMBLE: begin
               if (RX_Data == 8'hD5) begin
                  state_d = S_DST_MAC;
                  cnt_d   = '0;
                  uc_d    = 1'b1;
                  bc_d    = 1'b1;
               end else if (RX_Data == 8'h55) begin
                  state_d = S_PREAMBLE;
               end else begin
                  drop_now = 1'b1;
               end
            end
            S_DST_MAC: begin
               uc_d = uc_q && (RX_Data == mac_byte);
               bc_d = bc_q && (RX_Data == 8'hFF);
               if (!(uc_d || bc_d)) drop_now = 1'b1;
               else if (cnt_q == 5'd5) begin
                  state_d = S_SRC_MAC;
                  cnt_d   = '0;
               end
            end
            S_SRC_MAC: begin
               if (cnt_q == 5'd5) begin
                  state_d = S_ETYPE;
                  cnt_d   = '0;
               end
            end
            S_ETYPE: begin
               if (cnt_q == 5'd1) begin
                  if (word == 16'h0800) begin
                     state_d = S_IP_HDR;
                     cnt_d   = '0;
                     csum_d  = '0;
                  end else begin
                     drop_now = 1'b1;
                  end
               end
            end
            S_IP_HDR: begin
               if (cnt_q[0]) csum_d = csum_fold;
               if (cnt_q >= 5'd12 && cnt_q <= 5'd15) ip_hold_d = {ip_hold_q[23:0], RX_Data};
               if ((cnt_q == 5'd0 && RX_Data != 8'h45) ||
                   (cnt_q == 5'd9 && RX_Data != 8'h11) ||
                   (cnt_q >= 5'd16 && RX_Data != ip_byte) ||
                   (cnt_q == 5'd19 && csum_fold != 16'hFFFF)) begin
                  drop_now = 1'b1;
               end else if (cnt_q == 5'd19) begin
                  state_d = S_UDP_HDR;
                  cnt_d   = '0;
               end
            end
            S_UDP_HDR: begin
               if (cnt_q == 5'd1) port_hold_d = word;
               if (cnt_q == 5'd5) len_d = word;
               if ((cnt_q == 5'd3 && word != LOCAL_PORT) ||
                   (cnt_q == 5'd5 && word < 16'd8)) begin
                  drop_now = 1'b1;
               end else if (cnt_q == 5'd7) begin
                  // Frame accepted: publish its identity before the first payload byte
                  plen_d     = len_q - 16'd8;
                  rem_d      = len_q - 16'd8;
                  sip_d      = ip_hold_q;
                  sport_d    = port_hold_q;
                  sof_pend_d = 1'b1;
                  state_d    = (len_q > 16'd8) ? S_PAYLOAD : S_PAD_FCS;
                  cnt_d      = '0;
               end
            end
            S_PAYLOAD: begin
               pvalid_d   = 1'b1;
               pdata_d    = RX_Data;
               psof_d     = sof_pend_q;
               sof_pend_d = 1'b0;
               rem_d      = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  peof_d  = 1'b1;
                  state_d = S_PAD_FCS;
               end
            end
            default: ;   // WAIT_IDLE, DROP, PAD_FCS: absorb bytes until RX_DV falls
         endcase
         if (drop_now) state_d = S_DROP;
      end

      drop_d = ((drop_now || trunc) && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
   end

   // NOTE: sequential state uses nonblocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q     <= S_WAIT_IDLE;
         cnt_q       <= '0;
         hi_q        <= '0;
         csum_q      <= '0;
         crc_q       <= '1;
         uc_q        <= 1'b0;
         bc_q        <= 1'b0;
         ip_hold_q   <= '0;
         port_hold_q <= '0;
         len_q       <= '0;
         rem_q       <= '0;
         sof_pend_q  <= 1'b0;
         pvalid_q    <= 1'b0;
         pdata_q     <= '0;
         psof_q      <= 1'b0;
         peof_q      <= 1'b0;
         plen_q      <= '0;
         sip_q       <= '0;
         sport_q     <= '0;
         done_q      <= 1'b0;
         good_q      <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         csum_q      <= csum_d;
         crc_q       <= crc_d;
         uc_q        <= uc_d;
         bc_q        <= bc_d;
         ip_hold_q   <= ip_hold_d;
         port_hold_q <= port_hold_d;
         len_q       <= len_d;
         rem_q       <= rem_d;
         sof_pend_q  <= sof_pend_d;
         pvalid_q    <= pvalid_d;
         pdata_q     <= pdata_d;
         psof_q      <= psof_d;
         peof_q      <= peof_d;
         plen_q      <= plen_d;
         sip_q       <= sip_d;
         sport_q     <= sport_d;
         done_q      <= done_d;
         good_q      <= good_d;
         drop_q      <= drop_d;
      end
   end

   assign Payload_Valid = pvalid_q;
   assign Payload_Data  = pdata_q;
   assign Payload_SOF   = psof_q;
   assign Payload_EOF   = peof_q;
   assign Payload_Len   = plen_q;
   assign Src_IP        = sip_q;
   assign Src_Port      = sport_q;
   assign Frame_Done    = done_q;
   assign Frame_Good    = good_q;
   assign Drop_Cnt      = drop_q;

endmodule

// File: tb/tb_mac_udp_rx.sv
// -----------------------------------------------------------------------------
// tb_mac_udp_rx
//   Directed bench for mac_udp_rx. It builds complete frames itself, including
//   the IP checksum and the FCS. It drives the frames byte by byte. A negedge
//   monitor records the payload stream, SOF/EOF and Frame_Done/Frame_Good.
//   The main sequence compares these records against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_mac_udp_rx;

   localparam logic [47:0] LOCAL_MAC = 48'h081F7102C777;
   localparam logic [47:0] SRC_MAC   = 48'h02000000002C;
   localparam logic [47:0] BCAST     = 48'hFFFFFFFFFFFF;

   logic        clk = 1'b0;
   logic        RST;
   logic        RX_DV;
   logic [7:0]  RX_Data;
   logic        Payload_Valid;
   logic [7:0]  Payload_Data;
   logic        Payload_SOF;
   logic        Payload_EOF;
   logic [15:0] Payload_Len;
   logic [31:0] Src_IP;
   logic [15:0] Src_Port;
   logic        Frame_Done;
   logic        Frame_Good;
   logic [15:0] Drop_Cnt;

   always #5 clk = ~clk;

   mac_udp_rx dut (
      .clk(clk), .RST(RST), .RX_DV(RX_DV), .RX_Data(RX_Data),
      .Payload_Valid(Payload_Valid), .Payload_Data(Payload_Data),
      .Payload_SOF(Payload_SOF), .Payload_EOF(Payload_EOF),
      .Payload_Len(Payload_Len), .Src_IP(Src_IP), .Src_Port(Src_Port),
      .Frame_Done(Frame_Done), .Frame_Good(Frame_Good), .Drop_Cnt(Drop_Cnt)
   );

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;
   int drv_cyc  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor ----------------
   logic [7:0] pay_q[$];
   int         n_sof = 0, n_eof = 0, n_done = 0, sof_cyc = 0;
   logic [7:0] sof_byte = '0, eof_byte = '0;
   logic       last_good = 1'b0;

   always @(negedge clk) begin
      if (Payload_Valid) pay_q.push_back(Payload_Data);
      if (Payload_SOF) begin
         n_sof++;
         sof_byte = Payload_Data;
         sof_cyc  = cyc;
      end
      if (Payload_EOF) begin
         n_eof++;
         eof_byte = Payload_Data;
      end
      if (Frame_Done) begin
         n_done++;
         last_good = Frame_Good;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- frame construction ----------------
   logic [7:0] frm[$];

   function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int b = 0; b < 8; b++) begin
         fb = c[0] ^ d[b];
         c  = c >> 1;
         if (fb) c = c ^ 32'hEDB88320;
      end
      return c;
   endfunction

   task automatic build(input logic [47:0] da, input logic [15:0] etype,
                        input logic [31:0] dst_ip, input logic [15:0] dport,
                        input logic [15:0] ulen, input bit bad_csum,
                        input logic [7:0] fcs_xor);
      logic [7:0]  ip[20];
      logic [31:0] s, crc;
      logic [15:0] tot, csum;
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) frm.push_back(SRC_MAC[47-8*i -: 8]);
      frm.push_back(etype[15:8]);
      frm.push_back(etype[7:0]);
      tot = 16'd20 + ulen;
      ip = '{8'h45, 8'h00, tot[15:8], tot[7:0], 8'h12, 8'h34, 8'h40, 8'h00,
             8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h2C,
             dst_ip[31:24], dst_ip[23:16], dst_ip[15:8], dst_ip[7:0]};
      s = 0;
      for (int k = 0; k < 10; k++) s = s + {16'h0, ip[2*k], ip[2*k+1]};
      while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      csum = ~s[15:0];
      if (bad_csum) csum = csum ^ 16'h0001;
      ip[10] = csum[15:8];
      ip[11] = csum[7:0];
      for (int i = 0; i < 20; i++) frm.push_back(ip[i]);
      frm.push_back(8'h13); frm.push_back(8'h88);              // source port 5000
      frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
      frm.push_back(ulen[15:8]);  frm.push_back(ulen[7:0]);
      frm.push_back(8'h00); frm.push_back(8'h00);
      for (int i = 0; i < int'(ulen) - 8; i++) frm.push_back(8'(i));
      while (frm.size() < 60) frm.push_back(8'h00);
      crc = '1;
      foreach (frm[i]) crc = crc_upd(crc, frm[i]);
      crc = ~crc;
      frm.push_back(crc[7:0]);   frm.push_back(crc[15:8]);
      frm.push_back(crc[23:16]); frm.push_back(crc[31:24]);
      frm[frm.size()-1] = frm[frm.size()-1] ^ fcs_xor;
   endtask

   task automatic drive(input logic dv, input logic [7:0] d, input logic r);
      @(posedge clk);
      #1;
      RX_DV   = dv;
      RX_Data = d;
      RST     = r;
   endtask

   // Sends preamble, SFD and the first n frame bytes. RST pulses with byte rst_at.
   task automatic send(input int n, input int rst_at);
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, frm[i], 1'(i == rst_at));
         if (i == 42) drv_cyc = cyc;
      end
      repeat (12) drive(1'b0, 8'h00, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   int p0, s0, e0, d0, mism;

   task automatic mark();
      p0 = pay_q.size();
      s0 = n_sof;
      e0 = n_eof;
      d0 = n_done;
   endtask

   task automatic check_payload(input string tag, input int n);
      check({tag, "_count"}, pay_q.size() - p0, n);
      mism = 0;
      for (int i = 0; i < n; i++) begin
         if (p0 + i >= pay_q.size() || pay_q[p0+i] !== 8'(i)) mism++;
      end
      check({tag, "_bytes_wrong"}, mism, 0);
   endtask

   initial begin
      RST = 1'b1;
      RX_DV = 1'b0;
      RX_Data = 8'h00;
      repeat (4) @(posedge clk);
      #1 RST = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_flags", 32'({Payload_Valid, Payload_SOF, Payload_EOF, Frame_Done, Frame_Good}), 32'd0);
      check("rst_len", 32'(Payload_Len), 32'd0);
      check("rst_src_ip", Src_IP, 32'd0);
      check("rst_src_port", 32'(Src_Port), 32'd0);
      check("rst_drop", 32'(Drop_Cnt), 32'd0);

      // 1) default frame from the transmitter
      build(LOCAL_MAC, 16'h0800, 32'hC0A80002, 16'd6000, 16'd30, 1'b0, 8'h00);
      mark();
      send(frm.size(), -1);
      check_payload("t1_pay", 22);
      check("t1_sof_cnt", n_sof - s0, 1);
      check("t1_sof_byte", 32'(sof_byte), 32'h00);
      check("t1_latency", sof_cyc - drv_cyc, 1);
      check("t1_eof_cnt", n_eof - e0, 1);
      check("t1_eof_byte", 32'(eof_byte), 32'h15);
      check("t1_len", 32'(Payload_Len), 32'd22);
      check("t1_src_ip", Src_IP, 32'hC0A8002C);
      check("t1_src_port", 32'(Src_Port), 32'd5000);
      check("t1_done", n_done - d0, 1);
      check("t1_good", 32'(last_good), 32'd1);
      check("t1_drop", 32'(Drop_Cnt), 32'd0);

      // 2) corrupted FCS
      build(LOCAL_MAC, 16'h0800, 32'hC0A80002, 16'd6000, 16'd30, 1'b0, 8'h01);
      mark();
      send(frm.size(), -1);
      check_payload("t2_pay", 22);
      check("t2_eof_cnt", n_eof - e0, 1);
      check("t2_done", n_done - d0, 1);
      check("t2_good", 32'(last_good), 32'd0);

      // 3) four rejected frames
      mark();
      build(LOCAL_MAC, 16'h0800, 32'hC0A80003, 16'd6000, 16'd30, 1'b0, 8'h00);
      send(frm.size(), -1);
      check("t3_drop_ip", 32'(Drop_Cnt), 32'd1);
      build(LOCAL_MAC, 16'h0800, 32'hC0A80002, 16'd6001, 16'd30, 1'b0, 8'h00);
      send(frm.size(), -1);
      build(LOCAL_MAC, 16'h0806, 32'hC0A80002, 16'd6000, 16'd30, 1'b0, 8'h00);
      send(frm.size(), -1);
      build(LOCAL_MAC, 16'h0800, 32'hC0A80002, 16'd6000, 16'd30, 1'b1, 8'h00);
      send(frm.size(), -1);
      check("t3_pay_count", pay_q.size() - p0, 0);
      check("t3_sof_cnt", n_sof - s0, 0);
      check("t3_done", n_done - d0, 0);
      check("t3_drop", 32'(Drop_Cnt), 32'd4);

      // 4) broadcast DA with an empty payload
      build(BCAST, 16'h0800, 32'hC0A80002, 16'd6000, 16'd8, 1'b0, 8'h00);
      mark();
      send(frm.size(), -1);
      check("t4_pay_count", pay_q.size() - p0, 0);
      check("t4_sof_cnt", n_sof - s0, 0);
      check("t4_len", 32'(Payload_Len), 32'd0);
      check("t4_done", n_done - d0, 1);
      check("t4_good", 32'(last_good), 32'd1);
      check("t4_drop", 32'(Drop_Cnt), 32'd4);

      // 5) RX_DV falls after payload byte 0x09, then a normal frame
      build(LOCAL_MAC, 16'h0800, 32'hC0A80002, 16'd6000, 16'd30, 1'b0, 8'h00);
      mark();
      send(52, -1);
      check_payload("t5_pay", 10);
      check("t5_last_byte", 32'(pay_q[pay_q.size()-1]), 32'h09);
      check("t5_eof_cnt", n_eof - e0, 0);
      check("t5_done", n_done - d0, 1);
      check("t5_good", 32'(last_good), 32'd0);
      check("t5_drop", 32'(Drop_Cnt), 32'd4);
      mark();
      send(frm.size(), -1);
      check_payload("t5b_pay", 22);
      check("t5b_done", n_done - d0, 1);
      check("t5b_good", 32'(last_good), 32'd1);

      // 6) reset pulse inside the IP header, then a normal frame
      mark();
      send(frm.size(), 19);
      check("t6_pay_count", pay_q.size() - p0, 0);
      check("t6_done", n_done - d0, 0);
      check("t6_drop", 32'(Drop_Cnt), 32'd0);
      check("t6_src_ip", Src_IP, 32'd0);
      check("t6_len", 32'(Payload_Len), 32'd0);
      mark();
      send(frm.size(), -1);
      check_payload("t6b_pay", 22);
      check("t6b_sof_byte", 32'(sof_byte), 32'h00);
      check("t6b_eof_byte", 32'(eof_byte), 32'h15);
      check("t6b_src_ip", Src_IP, 32'hC0A8002C);
      check("t6b_done", n_done - d0, 1);
      check("t6b_good", 32'(last_good), 32'd1);
      check("t6b_drop", 32'(Drop_Cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
